// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered ring-network returns,
// with a starvation counter. Optional direct return path: CORE_WB_FIFO_BYPASS_EN.
module core_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pipe_regwrite,
    input  logic [4:0]                      pipe_dest_reg,
    input  logic [31:0]                     pipe_wdata,
    input  logic                            net_valid,
    input  logic [4:0]                      net_dest_reg,
    input  logic [31:0]                     net_data,
    output logic                            net_ready,
    output logic                            pipe_stall,
    output logic                            rf_we,
    output logic [4:0]                      rf_waddr,
    output logic [31:0]                     rf_wdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {GRANT_NONE, GRANT_PIPE, GRANT_FIFO, GRANT_NET} grant_e;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [3:0]         starve_cnt;
    grant_e             grant;
    logic               pipe_req, head_req, push, pop;
    entry_t             head;

    assign pipe_req   = pipe_regwrite && (pipe_dest_reg != 5'd0);
    assign head_req   = (count != '0);
    assign net_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign fifo_count = count;
    assign head       = mem[rd_ptr];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = GRANT_NONE;
        if (head_req && starve_cnt >= LIMIT)
            grant = GRANT_FIFO;
        else if (pipe_req)
            grant = GRANT_PIPE;
        else if (head_req)
            grant = GRANT_FIFO;
`ifdef CORE_WB_FIFO_BYPASS_EN
        else if (net_valid && net_dest_reg != 5'd0)
            grant = GRANT_NET;
`endif
    end

    assign pipe_stall = pipe_req && (grant != GRANT_PIPE);
    assign pop        = (grant == GRANT_FIFO);
    // r0 returns complete the handshake but are dropped; bypassed returns skip the FIFO.
    assign push       = net_valid && net_ready && (net_dest_reg != 5'd0) && (grant != GRANT_NET);

    // NOTE: storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{dest: net_dest_reg, data: net_data};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (!head_req || grant == GRANT_FIFO)
                starve_cnt <= '0;
            else if (grant == GRANT_PIPE && starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 1'b1;

            rf_we <= (grant != GRANT_NONE);
            case (grant)
                GRANT_PIPE: begin
                    rf_waddr <= pipe_dest_reg;
                    rf_wdata <= pipe_wdata;
                end
                GRANT_FIFO: begin
                    rf_waddr <= head.dest;
                    rf_wdata <= head.data;
                end
                GRANT_NET: begin
                    rf_waddr <= net_dest_reg;
                    rf_wdata <= net_data;
                end
                default: ;
            endcase
        end
    end

endmodule
